// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// State encoding and width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set req bit at or after rr_ptr,
// wrapping modulo N_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]             req,
  input  logic [clog2_min1(N_REQ)-1:0] rr_ptr,
  output logic [clog2_min1(N_REQ)-1:0] pick,
  output logic                         any
);

  localparam int IW = clog2_min1(N_REQ);

  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[(int'(rr_ptr) + k) % N_REQ]) begin
        any  = 1'b1;
        pick = IW'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// Owner keeps the port for up to BURST words; stalls on full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 8
) (
  input  logic                         clk,
  input  logic                         sync_reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*WIDTH-1:0]       req_data,
  output logic [N_REQ-1:0]             grant,
  output logic                         fifo_wr_en,
  output logic [WIDTH-1:0]             fifo_wr_data,
  input  logic                         fifo_full,
  input  logic                         fifo_almost_full,
  output logic                         owner_valid,
  output logic [clog2_min1(N_REQ)-1:0] owner_id
);

  localparam int IW = clog2_min1(N_REQ);
  localparam int BW = clog2_min1(BURST + 1);
  localparam logic [BW-1:0] LAST = BW'(BURST - 1);
  localparam logic [IW-1:0] TOP  = IW'(N_REQ - 1);

  state_t          state_q;
  state_t          state_n;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   rr_ptr_n;
  logic [IW-1:0]   owner_n;
  logic [BW-1:0]   beat_q;
  logic [BW-1:0]   beat_n;
  logic [IW-1:0]   pick;
  logic            pick_any;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req   (req),
    .rr_ptr(rr_ptr_q),
    .pick  (pick),
    .any   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_id <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_n;
      rr_ptr_q <= rr_ptr_n;
      owner_id <= owner_n;
      beat_q   <= beat_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    rr_ptr_n = rr_ptr_q;
    owner_n  = owner_id;
    beat_n   = beat_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any && !fifo_almost_full) begin
          state_n = OWN;
          owner_n = pick;
          beat_n  = '0;
        end
      end
      OWN: begin
        if (fifo_wr_en) beat_n = beat_q + 1'b1;
        // Release on dropped req or on the last word of a burst.
        if (!req[owner_id] ||
            (fifo_wr_en && beat_q == LAST)) begin
          state_n  = IDLE;
          rr_ptr_n = (owner_id == TOP) ? '0
                                       : owner_id + 1'b1;
          beat_n   = '0;
        end
      end
    endcase
  end

  always_comb begin
    grant = '0;
    if (state_q == OWN && !sync_reset && !fifo_full)
      grant[owner_id] = req[owner_id];
    fifo_wr_en   = |grant;
    fifo_wr_data = fifo_wr_en
                 ? req_data[int'(owner_id)*WIDTH +: WIDTH]
                 : '0;
    owner_valid  = (state_q == OWN);
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: BURST=2 and BURST=8 instances on
// shared stimulus, hand vectors plus a reference model.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int BUR [2] = '{2, 8};

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic             full;
  logic             af;

  logic [1:0][N-1:0] grant_w;
  logic [1:0]        wr_en_w;
  logic [1:0][W-1:0] data_w;
  logic [1:0]        valid_w;
  logic [1:0][1:0]   owner_w;

  int checks   = 0;
  int failures = 0;

  int m_own   [2];
  int m_owner [2];
  int m_ptr   [2];
  int m_beats [2];

  logic [N-1:0] obs_grant8;
  logic [1:0]   obs_owner8;
  logic         obs_valid8;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] exp_grant;
    logic         exp_valid;
  } vec_t;

  vec_t tbl [16];

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .BURST(2)) u_b2 (
    .clk             (clk),
    .sync_reset      (rst),
    .req             (req),
    .req_data        (req_data),
    .grant           (grant_w[0]),
    .fifo_wr_en      (wr_en_w[0]),
    .fifo_wr_data    (data_w[0]),
    .fifo_full       (full),
    .fifo_almost_full(af),
    .owner_valid     (valid_w[0]),
    .owner_id        (owner_w[0])
  );

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .BURST(8)) u_b8 (
    .clk             (clk),
    .sync_reset      (rst),
    .req             (req),
    .req_data        (req_data),
    .grant           (grant_w[1]),
    .fifo_wr_en      (wr_en_w[1]),
    .fifo_wr_data    (data_w[1]),
    .fifo_full       (full),
    .fifo_almost_full(af),
    .owner_valid     (valid_w[1]),
    .owner_id        (owner_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // One cycle: compare at negedge+1, then advance the model at posedge.
  task automatic cyc();
    logic [N-1:0] eg [2];
    #1;
    for (int u = 0; u < 2; u++) begin
      logic [W-1:0] ed;
      eg[u] = '0;
      ed    = '0;
      if (m_own[u] != 0 && !rst && !full && req[m_owner[u]]) begin
        eg[u][m_owner[u]] = 1'b1;
        ed = req_data[m_owner[u]*W +: W];
      end
      chk($sformatf("u%0d_grant", u), 64'(grant_w[u]), 64'(eg[u]));
      chk($sformatf("u%0d_wr_en", u), 64'(wr_en_w[u]), 64'(|eg[u]));
      chk($sformatf("u%0d_data", u), 64'(data_w[u]), 64'(ed));
      chk($sformatf("u%0d_valid", u), 64'(valid_w[u]), 64'(m_own[u] != 0));
      chk($sformatf("u%0d_owner", u), 64'(owner_w[u]), 64'(m_owner[u]));
    end
    obs_grant8 = grant_w[1];
    obs_owner8 = owner_w[1];
    obs_valid8 = valid_w[1];
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_own[u] = 0; m_owner[u] = 0; m_ptr[u] = 0; m_beats[u] = 0;
      end else if (m_own[u] == 0) begin
        if (req != '0 && !af) begin
          for (int i = 0; i < N; i++) begin
            int j = (m_ptr[u] + i) % N;
            if (req[j]) begin
              m_owner[u] = j; m_own[u] = 1; m_beats[u] = 0;
              break;
            end
          end
        end
      end else begin
        if (eg[u] != '0) m_beats[u]++;
        if (!req[m_owner[u]] || m_beats[u] == BUR[u]) begin
          m_own[u]   = 0;
          m_ptr[u]   = (m_owner[u] + 1) % N;
          m_beats[u] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; full = 1'b0; af = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [N-1:0] g9;
    rst = 1'b1; req = 4'hF; full = 1'b0; af = 1'b0;
    req_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_AAAA};
    for (int u = 0; u < 2; u++) begin
      m_own[u] = 0; m_owner[u] = 0; m_ptr[u] = 0; m_beats[u] = 0;
    end
    @(posedge clk);
    @(negedge clk);

    // Reset hold then round-robin on the BURST=2 instance.
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 4'h1, 1'b1};
    tbl[4]  = '{1'b0, 4'hF, 4'h1, 1'b1};
    tbl[5]  = '{1'b0, 4'hF, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 4'hF, 4'h2, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 4'h2, 1'b1};
    tbl[8]  = '{1'b0, 4'hF, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 4'hF, 4'h4, 1'b1};
    tbl[10] = '{1'b0, 4'hF, 4'h4, 1'b1};
    tbl[11] = '{1'b0, 4'hF, 4'h0, 1'b0};
    tbl[12] = '{1'b0, 4'hF, 4'h8, 1'b1};
    tbl[13] = '{1'b0, 4'hF, 4'h8, 1'b1};
    tbl[14] = '{1'b0, 4'hF, 4'h0, 1'b0};
    tbl[15] = '{1'b0, 4'hF, 4'h1, 1'b1};
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst;
      req = tbl[i].req;
      #1;
      chk($sformatf("tbl%0d_grant", i), 64'(grant_w[0]), 64'(tbl[i].exp_grant));
      chk($sformatf("tbl%0d_valid", i), 64'(valid_w[0]), 64'(tbl[i].exp_valid));
      cyc();
    end

    // Burst cap: lone requester 2 on BURST=8.
    do_reset();
    req = 4'b0100;
    n = 0;
    g9 = 'x;
    for (int k = 0; k < 18; k++) begin
      cyc();
      if (obs_grant8 == 4'b0100) n++;
      if (k == 9) g9 = obs_grant8;
    end
    chk("cap_grants", 64'(n), 64'd16);
    chk("cap_idle", 64'(g9), 64'd0);

    // Full stall mid-burst at beat 3.
    do_reset();
    req = 4'b0010;
    cyc();
    n = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (obs_grant8 == 4'b0010) n++;
    end
    chk("stall_pre", 64'(n), 64'd3);
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_grant", 64'(obs_grant8), 64'd0);
      chk("stall_owner", 64'(obs_owner8), 64'd1);
    end
    full = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (obs_grant8 == 4'b0010) n++;
    end
    chk("stall_post", 64'(n), 64'd5);
    cyc();
    chk("stall_release", 64'(obs_valid8), 64'd0);

    // Almost-full hysteresis in IDLE.
    do_reset();
    req = 4'h6;
    af  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("af_idle", 64'(obs_valid8), 64'd0);
    end
    af = 1'b0;
    cyc();
    cyc();
    chk("af_owner", 64'(obs_owner8), 64'd1);
    chk("af_valid", 64'(obs_valid8), 64'd1);

    // Early release by owner 3, wrap to index 0.
    do_reset();
    req = 4'b1000;
    cyc();
    cyc();
    cyc();
    req = 4'b0011;
    cyc();
    chk("early_nogrant", 64'(obs_grant8), 64'd0);
    cyc();
    chk("early_idle", 64'(obs_valid8), 64'd0);
    cyc();
    chk("early_owner", 64'(obs_owner8), 64'd0);
    chk("early_valid", 64'(obs_valid8), 64'd1);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      req  = N'($urandom);
      full = ($urandom_range(0, 4) == 0);
      af   = ($urandom_range(0, 3) == 0);
      for (int s = 0; s < N; s++) req_data[s*W +: W] = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
